vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

AXI-Stream test-pattern source that sits directly upstream of the VGA timing/output stage and drives its pixel stream input. Generates one frame at a time of H_RES x V_RES 12-bit RGB pixels in raster order, marks start-of-frame on tuser and end-of-line on tlast, and holds data under backpressure. The downstream stage accepts pixels only during its active video region, so backpressure fully paces the generator.

## Interface
Parameters:
- FCNT_W, 8, width of the frame counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- init  in  1  synchronous restart; drive together with the downstream stage's init.
- pat_sel  in  2  pattern: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient.
- solid_rgb  in  12  colour for pattern 0: [3:0] R, [7:4] G, [11:8] B.
- H_RES  in  16  active pixels per line.
- V_RES  in  16  active lines per frame.
- m_tvalid  out  1  pixel valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  12  pixel: [3:0] R, [7:4] G, [11:8] B.
- m_tlast  out  1  last pixel of a line.
- m_tuser  out  1  first pixel of a frame.
- frame_cnt  out  FCNT_W  completed frames, wraps.

## Operation
- Counters x (0..H_RES-1) and y (0..V_RES-1) give the position of the next pixel to load into the output register.
- Load condition: !m_tvalid || m_tready. On load: m_tdata = f(x, y), m_tlast = (x == H_RES-1), m_tuser = (x == 0 && y == 0), m_tvalid = 1, then advance x. Wrap x to 0 and increment y at the end of a line. Wrap y to 0 at the end of a frame.
- While m_tvalid && !m_tready: all outputs held stable. No counter change.
- pat_sel and solid_rgb are sampled into shadow registers only when pixel (0,0) loads. A mid-frame change applies from the next frame.
- H_RES and V_RES are quasi-static and may change only with init asserted. A value of 0 is treated as 1.
- Pattern 0: solid_rgb.
- Pattern 1: 8 vertical bars, width bw = max(H_RES>>3, 1).
  - Bar index comes from a per-line bar counter, not a divider. It resets at x=0, steps every bw pixels and saturates at 7, so the last bar absorbs the remainder.
  - Colours, index 0..7: white FFF, yellow 0FF, cyan FF0, green 0F0, magenta F0F, red 00F, blue F00, black 000 (as B,G,R nibbles in m_tdata[11:0]).
- Pattern 2: 16x16 checker. x[4]^y[4] = 0 gives FFF, 1 gives 000.
- Pattern 3: R = xs[7:4], G = y[7:4], B = (xs+y)[8:5], computed with a 17-bit sum. xs = x + offset, truncated to 16 bits; offset is set under Configuration.
- frame_cnt increments on the handshake (m_tvalid && m_tready) of the pixel with m_tuser... no: on the handshake of the last pixel of a frame (x = H_RES-1, y = V_RES-1). It wraps modulo 2^FCNT_W.

## Timing
- Reset values: m_tvalid 0, m_tdata 0, m_tlast 0, m_tuser 0, frame_cnt 0, x = y = 0, shadow pat_sel 0, shadow solid_rgb 0.
- First clock edge after reset release: pixel (0,0) loads, so m_tvalid = 1 and m_tuser = 1.
- Throughput is 1 pixel/cycle under continuous m_tready. Latency from counter position to output is 1 cycle.
- init (highest priority, overrides load) clears m_tvalid, m_tlast, m_tuser and x, y in that cycle. frame_cnt is not cleared. Pixel (0,0) loads on the next edge.
- An init arriving during a stalled beat drops that beat.
- Reset mid-frame: all state returns to reset values asynchronously.
- H_RES = 1: every pixel has m_tlast = 1.
- H_RES = 1 and V_RES = 1: every pixel has m_tuser = m_tlast = 1, and frame_cnt increments on every handshake.

## Configuration
- VGA_PATGEN_SCROLL_EN defined: offset = frame_cnt zero-extended to 16 bits, so the gradient shifts one pixel left per frame.
- VGA_PATGEN_SCROLL_EN undefined: offset = 0 and the gradient is static. frame_cnt still counts.

## Test plan
- Reset release, H_RES=16, V_RES=4, pat_sel=0, solid_rgb=0x5A3, m_tready=1:
  - 64 beats, all m_tdata = 0x5A3.
  - m_tuser only on beat 0.
  - m_tlast on beats 15, 31, 47, 63.
  - frame_cnt = 1 after beat 63.
- pat_sel=1, H_RES=20: bw=2.
  - Beats 0-1 = FFF, 2-3 = 0FF, … 12-13 = F00.
  - Beats 14-19 = 000 (remainder absorbed by bar 7).
- m_tready toggling 1,0,0,1 at each beat: every beat is accepted exactly once, in order, with tdata/tlast/tuser stable while stalled. Compare against a reference model for 3 frames.
- pat_sel 2→3 written at beat 10 of a frame: the rest of that frame stays checker; the next frame's first beat (tuser=1) is gradient.
- init pulsed at beat 37 with m_tready=0:
  - Next cycle m_tvalid = 0.
  - The following cycle m_tvalid = 1, m_tuser = 1, pixel (0,0).
  - frame_cnt unchanged.
- Pattern 3, H_RES=16, V_RES=1, 3 frames:
  - With VGA_PATGEN_SCROLL_EN: x=15 in frame 2 gives R = (15+2)[7:4] = 1.
  - Without it: R = 0 for all beats.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// AXI-Stream test-pattern source: solid, colour bars, checkerboard or gradient frames in raster order.
// Define VGA_PATGEN_SCROLL_EN to scroll the gradient one pixel left per completed frame.
`timescale 1ns/1ps
module vga_pattern_gen #(
  parameter int FCNT_W = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              init,
  input  logic [1:0]        pat_sel,
  input  logic [11:0]       solid_rgb,
  input  logic [15:0]       H_RES,
  input  logic [15:0]       V_RES,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [11:0]       m_tdata,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic [FCNT_W-1:0] frame_cnt
);

  // Handshake: a beat transfers on an edge where m_tvalid && m_tready; while
  // m_tvalid && !m_tready every output is held and no counter moves.

  logic [15:0]       x_q, x_d, y_q, y_d;
  logic [15:0]       bar_cnt_q, bar_cnt_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [1:0]        sel_q, sel_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic              eof_q, eof_d;
  logic [11:0]       tdata_q, tdata_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [15:0] h_max, v_max, bw, offset, xs;
  logic [16:0] grad_sum;
  logic [1:0]  cur_sel;
  logic [11:0] cur_rgb, pixel;
  logic        at_origin, x_end, y_end, load;

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'h0FF;
      3'd2:    return 12'hFF0;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'h00F;
      3'd6:    return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

  always_comb begin
    h_max     = (H_RES == 16'd0) ? 16'd0 : H_RES - 16'd1;
    v_max     = (V_RES == 16'd0) ? 16'd0 : V_RES - 16'd1;
    bw        = (H_RES[15:3] == 13'd0) ? 16'd1 : {3'd0, H_RES[15:3]};
    at_origin = (x_q == 16'd0) && (y_q == 16'd0);
    x_end     = (x_q >= h_max);
    y_end     = (y_q >= v_max);
    load      = !tvalid_q || m_tready;
    // The first pixel of a frame uses the live selection, later pixels the shadow copy.
    cur_sel   = at_origin ? pat_sel : sel_q;
    cur_rgb   = at_origin ? solid_rgb : rgb_q;
`ifdef VGA_PATGEN_SCROLL_EN
    offset    = 16'(fcnt_q);
`else
    offset    = 16'd0;
`endif
    xs        = x_q + offset;
    grad_sum  = {1'b0, xs} + {1'b0, y_q};
    case (cur_sel)
      2'd0:    pixel = cur_rgb;
      2'd1:    pixel = bar_colour(bar_idx_q);
      2'd2:    pixel = (x_q[4] ^ y_q[4]) ? 12'h000 : 12'hFFF;
      default: pixel = {4'(grad_sum >> 5), 4'(y_q >> 4), 4'(xs >> 4)};
    endcase
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    sel_d     = sel_q;
    rgb_d     = rgb_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    eof_d     = eof_q;
    tdata_d   = tdata_q;
    fcnt_d    = fcnt_q;
    if (load) begin
      tdata_d  = pixel;
      tlast_d  = x_end;
      tuser_d  = at_origin;
      eof_d    = x_end && y_end;
      tvalid_d = 1'b1;
      if (at_origin) begin
        sel_d = pat_sel;
        rgb_d = solid_rgb;
      end
      if (x_end) begin
        x_d       = 16'd0;
        y_d       = y_end ? 16'd0 : y_q + 16'd1;
        bar_cnt_d = 16'd0;
        bar_idx_d = 3'd0;
      end else begin
        x_d = x_q + 16'd1;
        // Bar index steps every bw pixels and sticks at 7 to absorb the remainder.
        if (bar_cnt_q >= bw - 16'd1) begin
          bar_cnt_d = 16'd0;
          if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + 16'd1;
        end
      end
    end
    if (tvalid_q && m_tready && eof_q) fcnt_d = fcnt_q + 1'b1;
    if (init) begin
      // Restart drops any pending beat; frame count and shadows survive.
      tvalid_d  = 1'b0;
      tlast_d   = 1'b0;
      tuser_d   = 1'b0;
      eof_d     = 1'b0;
      tdata_d   = tdata_q;
      x_d       = 16'd0;
      y_d       = 16'd0;
      bar_cnt_d = 16'd0;
      bar_idx_d = 3'd0;
      sel_d     = sel_q;
      rgb_d     = rgb_q;
      fcnt_d    = fcnt_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x_q       <= '0;
      y_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      sel_q     <= '0;
      rgb_q     <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      eof_q     <= 1'b0;
      tdata_q   <= '0;
      fcnt_q    <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      sel_q     <= sel_d;
      rgb_q     <= rgb_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      eof_q     <= eof_d;
      tdata_q   <= tdata_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign m_tvalid  = tvalid_q;
  assign m_tdata   = tdata_q;
  assign m_tlast   = tlast_q;
  assign m_tuser   = tuser_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: randomized backpressure and geometry against a frame-level reference model.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

  // ---------------- clock / reset ----------------
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        init = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic [15:0] H_RES = 16'd16;
  logic [15:0] V_RES = 16'd4;
  logic        m_tready = 1'b0;
  logic        m_tvalid, m_tlast, m_tuser;
  logic [11:0] m_tdata;
  logic [7:0]  frame_cnt;

  always #5 aclk = ~aclk;

  vga_pattern_gen #(.FCNT_W(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .init(init), .pat_sel(pat_sel),
    .solid_rgb(solid_rgb), .H_RES(H_RES), .V_RES(V_RES),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .frame_cnt(frame_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];   // {end_of_frame, tuser, tlast, tdata}
  int model_fc = 0;
  bit fresh = 1'b1;
  bit prev_stall = 1'b0;
  logic [14:0] prev_out;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] bar_colour(input int i);
    case (i)
      0: return 12'hFFF;
      1: return 12'h0FF;
      2: return 12'hFF0;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'h00F;
      6: return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] model_pix(input int x, input int y, input int pat,
                                            input logic [11:0] rgb, input int h, input int off);
    int bw, idx, xs;
    logic [3:0] r, g, b;
    case (pat)
      0: return rgb;
      1: begin
        bw = h / 8;
        if (bw < 1) bw = 1;
        idx = x / bw;
        if (idx > 7) idx = 7;
        return bar_colour(idx);
      end
      2: return ((((x / 16) + (y / 16)) % 2) == 1) ? 12'h000 : 12'hFFF;
      default: begin
        xs = (x + off) % 65536;
        r = 4'((xs / 16) % 16);
        g = 4'((y / 16) % 16);
        b = 4'(((xs + y) / 32) % 16);
        return {b, g, r};
      end
    endcase
  endfunction

  function automatic int eff_h();
    return (H_RES == 16'd0) ? 1 : int'(H_RES);
  endfunction

  function automatic int eff_v();
    return (V_RES == 16'd0) ? 1 : int'(V_RES);
  endfunction

  // Offset applied to pixel (0,0) of this frame: it loads on the same edge that
  // completes the previous frame, so it still sees the old count.
  function automatic int model_offset(input bit first);
`ifdef VGA_PATGEN_SCROLL_EN
    if (first && !fresh) return (model_fc + 255) % 256;
    return model_fc % 256;
`else
    return 0;
`endif
  endfunction

  task automatic build_frame();
    int h, v;
    logic eof, usr, lst;
    h = eff_h();
    v = eff_v();
    for (int y = 0; y < v; y++) begin
      for (int x = 0; x < h; x++) begin
        eof = (x == h - 1) && (y == v - 1);
        usr = (x == 0) && (y == 0);
        lst = (x == h - 1);
        exp_q.push_back({eof, usr, lst,
                         model_pix(x, y, int'(pat_sel), solid_rgb, h, model_offset(usr))});
      end
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    fresh = 1'b1;
    prev_stall = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit rdy, output bit hs);
    logic [14:0] e;
    @(negedge aclk);
    cyc++;
    if (prev_stall) check("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, prev_out);
    m_tready = rdy;
    check("frame_cnt", frame_cnt, model_fc % 256);
    hs = m_tvalid && rdy;
    if (hs) begin
      if (exp_q.size() == 0) build_frame();
      e = exp_q.pop_front();
      check("beat", {m_tuser, m_tlast, m_tdata}, e[13:0]);
      if (e[14]) model_fc++;
      fresh = 1'b0;
    end
    prev_stall = m_tvalid && !rdy;
    prev_out = {m_tvalid, m_tuser, m_tlast, m_tdata};
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_beats(input int n, input int mode);
    int got, budget;
    bit rdy, hs;
    got = 0;
    budget = n * 8 + 64;
    while (got < n && budget > 0) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      step(rdy, hs);
      if (hs) got++;
      budget--;
    end
    if (got < n) check("beat_budget", got, n);
  endtask

  task automatic do_init(input logic [1:0] pat, input int h, input int v, input logic [11:0] rgb);
    @(negedge aclk);
    m_tready = 1'b0;
    init = 1'b1;
    pat_sel = pat;
    H_RES = 16'(h);
    V_RES = 16'(v);
    solid_rgb = rgb;
    @(negedge aclk);
    init = 1'b0;
    check("init_valid", m_tvalid, 0);
    flush_model();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int fc_saved, h, v;
    bit hs;
    logic [1:0] p;

    H_RES = 16'd16; V_RES = 16'd4; pat_sel = 2'd0; solid_rgb = 12'h5A3;
    repeat (3) @(negedge aclk);
    check("rst_valid", m_tvalid, 0);
    check("rst_data", {m_tuser, m_tlast, m_tdata}, 0);
    check("rst_fcnt", frame_cnt, 0);
    aresetn = 1'b1;
    m_tready = 1'b0;
    @(negedge aclk);
    check("first_valid", m_tvalid, 1);
    check("first_user", m_tuser, 1);
    check("first_data", m_tdata, 12'h5A3);

    // Solid colour frame, continuous ready
    run_beats(64, 0);
    step(1'b0, hs);
    check("fcnt_one_frame", frame_cnt, 1);

    // Colour bars with remainder absorbed by bar 7
    do_init(2'd1, 20, 2, 12'h000);
    run_beats(40, 0);

    // Checkerboard under 1,0,0,1 ready pattern for 3 frames
    do_init(2'd2, 16, 4, 12'h000);
    run_beats(192, 1);

    // Pattern change mid-frame takes effect on the next frame
    run_beats(10, 0);
    pat_sel = 2'd3;
    run_beats(54 + 64, 2);

    // init during a stalled beat
    run_beats(37, 0);
    fc_saved = model_fc;
    do_init(2'd3, 16, 4, 12'h000);
    step(1'b0, hs);
    check("reinit_valid", m_tvalid, 1);
    check("reinit_user", m_tuser, 1);
    check("reinit_pix", m_tdata, model_pix(0, 0, 3, 12'h000, 16, model_offset(1'b1)));
    check("reinit_fcnt", frame_cnt, fc_saved % 256);
    run_beats(64, 0);

    // Gradient, single-line frames
    do_init(2'd3, 16, 1, 12'h000);
    run_beats(48, 0);

    // Random geometries including 1x1 and zero sizes
    for (int it = 0; it < 8; it++) begin
      h = (it == 0) ? 1 : (it == 1) ? 0 : $urandom_range(0, 40);
      v = (it == 0) ? 1 : (it == 1) ? 0 : $urandom_range(0, 3);
      p = 2'($urandom_range(0, 3));
      do_init(p, h, v, 12'($urandom_range(0, 4095)));
      run_beats(3 * eff_h() * eff_v() + int'($urandom_range(0, 5)), 2);
    end

    // Asynchronous reset mid-frame
    do_init(2'd0, 16, 4, 12'h1C7);
    run_beats(90, 2);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("midrst_valid", m_tvalid, 0);
    check("midrst_out", {m_tuser, m_tlast, m_tdata}, 0);
    check("midrst_fcnt", frame_cnt, 0);
    model_fc = 0;
    flush_model();
    @(negedge aclk);
    aresetn = 1'b1;
    m_tready = 1'b0;
    run_beats(128, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
